// File: rtl/kw_gate_pkg.sv
// rtl/kw_gate_pkg.sv - shared FSM encoding and stored-word width for kw_verdict_gate
package kw_gate_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  // Stored word is {tdata, tkeep, tlast, tuser}.
  localparam int WORD_W = DATA_W + KEEP_W + 1 + 1;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    WAIT_VERDICT,
    FORWARD,
    DROP
  } state_t;

endpackage

// File: rtl/kw_gate_buffer.sv
// rtl/kw_gate_buffer.sv - simple dual-port packet RAM, DEPTH x WORD_W, registered read
module kw_gate_buffer
  import kw_gate_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // rd_data only moves on rd_en, so the reader can treat it as a holding stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/kw_verdict_gate.sv
// rtl/kw_verdict_gate.sv - holds one text packet until the keyword matcher approves or blocks it
// Optional packet counters fwd_count/drop_count are built when KW_GATE_STATS_EN is defined.
module kw_verdict_gate
  import kw_gate_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_axis_text_tdata,
  input  logic [7:0]  s_axis_text_tkeep,
  input  logic        s_axis_text_tvalid,
  output logic        s_axis_text_tready,
  input  logic        s_axis_text_tlast,
  input  logic        s_axis_text_tuser,
  output logic [63:0] m_axis_text_tdata,
  output logic [7:0]  m_axis_text_tkeep,
  output logic        m_axis_text_tvalid,
  input  logic        m_axis_text_tready,
  output logic        m_axis_text_tlast,
  output logic        m_axis_text_tuser,
  input  logic        match_sig,
  input  logic        no_match_sig,
  output logic        ack
`ifdef KW_GATE_STATS_EN
  ,
  output logic [31:0] fwd_count,
  output logic [31:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              overflow;
  logic              verdict_valid;
  logic              verdict_match;
  logic              s1_valid;
  logic [TW-1:0]     tcnt;
  logic [WORD_W-1:0] rd_data;
  logic              accepting, full, in_fire, wr_en, rd_en;
  logic              s1_take, out_fire, verdict_hit, latch_now;

  assign accepting   = (state == IDLE) || (state == STORE);
  assign full        = wr_ptr[AW];
  // A full buffer keeps accepting so the rest of the packet drains into the overflow discard.
  assign s_axis_text_tready = accepting && !reset;
  assign in_fire     = s_axis_text_tvalid && s_axis_text_tready;
  assign wr_en       = in_fire && !full && !overflow;
  assign s1_take     = s1_valid && (!m_axis_text_tvalid || m_axis_text_tready);
  assign rd_en       = (state == FORWARD) && (rd_ptr != wr_ptr) && (!s1_valid || s1_take);
  assign out_fire    = m_axis_text_tvalid && m_axis_text_tready;
  assign verdict_hit = match_sig || no_match_sig;
  assign latch_now   = ((state == STORE) || (state == WAIT_VERDICT)) && !verdict_valid && !ack && verdict_hit;

  kw_gate_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis_text_tdata, s_axis_text_tkeep, s_axis_text_tlast, s_axis_text_tuser}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      overflow           <= 1'b0;
      verdict_valid      <= 1'b0;
      verdict_match      <= 1'b0;
      tcnt               <= '0;
      ack                <= 1'b0;
      s1_valid           <= 1'b0;
      m_axis_text_tvalid <= 1'b0;
      m_axis_text_tlast  <= 1'b0;
      m_axis_text_tuser  <= 1'b0;
      m_axis_text_tdata  <= '0;
      m_axis_text_tkeep  <= '0;
    end else begin
      ack <= latch_now || (ack && verdict_hit);
      if (latch_now) begin
        verdict_valid <= 1'b1;
        verdict_match <= match_sig;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      else if (in_fire) overflow <= 1'b1;

      case (state)
        IDLE, STORE: begin
          if (in_fire) begin
            state <= s_axis_text_tlast ? WAIT_VERDICT : STORE;
            // tcnt counts cycles since tlast, so DROP lands exactly TIMEOUT cycles after it.
            if (s_axis_text_tlast) tcnt <= TW'(1);
          end
        end
        WAIT_VERDICT: begin
          if (overflow) state <= DROP;
          else if (verdict_valid) state <= verdict_match ? DROP : FORWARD;
          else if (tcnt == TW'(TIMEOUT - 1)) state <= DROP;
          else tcnt <= tcnt + 1'b1;
        end
        FORWARD: begin
          if (rd_en) rd_ptr <= rd_ptr + 1'b1;
          if (rd_en) s1_valid <= 1'b1;
          else if (s1_take) s1_valid <= 1'b0;
          if (!m_axis_text_tvalid || m_axis_text_tready) begin
            m_axis_text_tvalid <= s1_valid;
            if (s1_valid)
              {m_axis_text_tdata, m_axis_text_tkeep, m_axis_text_tlast, m_axis_text_tuser} <= rd_data;
          end
          if (out_fire && m_axis_text_tlast) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            overflow           <= 1'b0;
            verdict_valid      <= 1'b0;
            verdict_match      <= 1'b0;
            tcnt               <= '0;
            s1_valid           <= 1'b0;
            m_axis_text_tvalid <= 1'b0;
            m_axis_text_tlast  <= 1'b0;
          end
        end
        DROP: begin
          state         <= IDLE;
          wr_ptr        <= '0;
          rd_ptr        <= '0;
          overflow      <= 1'b0;
          verdict_valid <= 1'b0;
          verdict_match <= 1'b0;
          tcnt          <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KW_GATE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      if ((state == FORWARD) && out_fire && m_axis_text_tlast && (fwd_count != '1))
        fwd_count <= fwd_count + 1'b1;
      if ((state == DROP) && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kw_verdict_gate.sv
// tb/tb_kw_verdict_gate.sv - scoreboard bench for kw_verdict_gate (DEPTH=16, TIMEOUT=8)
module tb_kw_verdict_gate;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic        match_sig = 1'b0;
  logic        no_match_sig = 1'b0;
  logic        ack;
`ifdef KW_GATE_STATS_EN
  logic [31:0] fwd_count;
  logic [31:0] drop_count;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    fwd_exp = 0;
  int    drop_exp = 0;
  beat_t exp_q[$];
  logic  ready_pat[$];

  kw_verdict_gate #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .s_axis_text_tdata  (s_tdata),
    .s_axis_text_tkeep  (s_tkeep),
    .s_axis_text_tvalid (s_tvalid),
    .s_axis_text_tready (s_tready),
    .s_axis_text_tlast  (s_tlast),
    .s_axis_text_tuser  (s_tuser),
    .m_axis_text_tdata  (m_tdata),
    .m_axis_text_tkeep  (m_tkeep),
    .m_axis_text_tvalid (m_tvalid),
    .m_axis_text_tready (m_tready),
    .m_axis_text_tlast  (m_tlast),
    .m_axis_text_tuser  (m_tuser),
    .match_sig          (match_sig),
    .no_match_sig       (no_match_sig),
    .ack                (ack)
`ifdef KW_GATE_STATS_EN
    ,
    .fwd_count          (fwd_count),
    .drop_count         (drop_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Sink: scripted tready pattern while data is offered, otherwise always-ready or random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_pat.size() > 0 && m_tvalid) m_tready = ready_pat.pop_front();
      else if (ready_mode == 1) m_tready = 1'b1;
      else m_tready = ($urandom % 3) != 0;
    end
  end

  // Monitor: every output handshake must match the oldest approved beat.
  initial begin
    logic        held = 1'b0;
    logic [73:0] prev = '0;
    logic [73:0] cur;
    forever begin
      @(negedge clk);
      cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) check("hold_stable", cur, prev);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", cur);
          end else begin
            check("beat", cur, exp_q.pop_front());
          end
        end
        held = m_tvalid && !m_tready;
        prev = cur;
      end
    end
  end

  // vmode 0: no verdict, 1: verdict once vk beats are accepted, 2: verdict vd cycles after tlast.
  task automatic send_pkt(input int n, input int vmode, input int vk, input bit vm, input bit vn,
                          input int vd, input int vl, input bit gaps,
                          output int sent, output int low, output int ackc, output int ackd);
    beat_t b[$];
    beat_t bt;
    bit    fire = 0, tl = 0, back = 0, von;
    int    after = 0, vcnt = 0, vfirst = -1, afirst = -1, guard = 0;
    for (int i = 0; i < n; i++) begin
      bt.d = {$urandom, $urandom};
      bt.k = (i == n - 1) ? 8'h0F : 8'($urandom);
      bt.l = (i == n - 1);
      bt.u = 1'($urandom);
      b.push_back(bt);
    end
    if (n <= DEPTH && vmode != 0 && vn && !vm) begin
      foreach (b[i]) exp_q.push_back(b[i]);
      fwd_exp++;
    end else begin
      drop_exp++;
    end
    sent = 0; low = 0; ackc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tl) after++;
      if (fire) begin
        sent++;
        if (sent == n) begin tl = 1; after = 0; end
      end
      if (sent < n) begin
        s_tvalid = gaps ? (($urandom % 4) != 0) : 1'b1;
        {s_tdata, s_tkeep, s_tlast, s_tuser} = b[sent];
      end else begin
        s_tvalid = 1'b0;
      end
      von = (vcnt < vl) && ((vmode == 1 && sent >= vk) || (vmode == 2 && tl && after >= vd));
      match_sig = von & vm;
      no_match_sig = von & vn;
      if (von) begin
        if (vcnt == 0) vfirst = cyc;
        vcnt++;
      end
      @(negedge clk);
      fire = s_tvalid && s_tready;
      if (ack) begin
        ackc++;
        if (afirst < 0) afirst = cyc;
      end
      if (tl && !back) begin
        if (s_tready) back = 1;
        else low++;
      end
      if (back && !ack && (vmode == 0 || vcnt == vl) && !match_sig && !no_match_sig) break;
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("FAIL packet_timeout actual=%0d required=<400 cycles", guard);
        break;
      end
    end
    s_tvalid = 1'b0;
    match_sig = 1'b0;
    no_match_sig = 1'b0;
    ackd = (vfirst >= 0 && afirst >= 0) ? afirst - vfirst : -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0t required=earlier", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int sent, low, ackc, ackd, n, vmode, vk, r, g;
    bit vm, vn;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_ack", ack, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_tready", s_tready, 1);

    ready_mode = 1;
    send_pkt(3, 2, 0, 0, 1, 0, 2, 0, sent, low, ackc, ackd);
    check("nomatch_ack_cycles", ackc, 2);
    check("nomatch_all_out", exp_q.size(), 0);

    send_pkt(5, 1, 1, 1, 0, 0, 1, 0, sent, low, ackc, ackd);
    check("match_ack_latency", ackd, 1);
    check("match_ack_cycles", ackc, 1);

    send_pkt(20, 2, 0, 0, 1, 0, 1, 0, sent, low, ackc, ackd);
    check("overflow_accepted", sent, 20);

    send_pkt(2, 0, 0, 0, 0, 0, 0, 0, sent, low, ackc, ackd);
    check("timeout_cycles", low, TIMEOUT);
    @(negedge clk);
    check("timeout_idle_tready", s_tready, 1);

    send_pkt(3, 2, 0, 1, 1, 1, 1, 0, sent, low, ackc, ackd);

    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_pkt(4, 2, 0, 0, 1, 0, 1, 0, sent, low, ackc, ackd);
    check("toggle_ready_out", exp_q.size(), 0);

    ready_mode = 0;
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 20);
      vmode = (n == 1) ? (($urandom % 4 == 0) ? 0 : 2) : $urandom_range(0, 2);
      if (vmode == 0 && ($urandom % 2 == 0)) vmode = 2;
      vk = (n > 1) ? $urandom_range(1, n - 1) : 1;
      r = $urandom % 4;
      vm = (r == 0) || (r == 1);
      vn = (r != 0);
      send_pkt(n, vmode, vk, vm, vn, $urandom_range(0, 4), $urandom_range(1, 3), 1,
               sent, low, ackc, ackd);
    end
    check("random_all_out", exp_q.size(), 0);

    ready_mode = 1;
    fork
      send_pkt(4, 2, 0, 0, 1, 0, 1, 0, sent, low, ackc, ackd);
      begin
        g = 0;
        do begin
          @(negedge clk);
          #1;
          g++;
        end while (exp_q.size() != 3 && g < 200);
        if (g >= 200) begin
          checks++;
          errors++;
          $display("FAIL first_beat_wait actual=%0d required=<200 cycles", g);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        fwd_exp = 0;
        drop_exp = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_m_tlast", m_tlast, 0);
        check("midrst_ack", ack, 0);
        check("midrst_s_tready", s_tready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
      end
    join
    send_pkt(4, 2, 0, 0, 1, 2, 1, 0, sent, low, ackc, ackd);
    check("post_reset_out", exp_q.size(), 0);

`ifdef KW_GATE_STATS_EN
    check("fwd_count", fwd_count, fwd_exp);
    check("drop_count", drop_count, drop_exp);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
